// File: rtl/spi_response_arbiter_pkg.sv
// Shared types and constants for the SPI response arbiter.
// The TIMEOUT state exists only when SPI_RESPONSE_TIMEOUT_EN is defined.
package spi_response_arbiter_pkg;

`ifdef SPI_RESPONSE_TIMEOUT_EN
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD, S_TIMEOUT} state_e;
`else
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_e;
`endif

    localparam logic [7:0] NO_RESPONSE_BYTE   = 8'hFF;
    localparam logic [7:0] IDLE_RESPONSE_BYTE = 8'h00;

endpackage

// File: rtl/spi_priority_select.sv
// Fixed-priority (lowest index wins) one-hot selector with a multiple-request flag.
module spi_priority_select #(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0] req_in,
    output logic [NUM_REQ-1:0] grant_out,
    output logic               multi_out
);

    logic found;

    always_comb begin
        grant_out = '0;
        multi_out = 1'b0;
        found     = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_in[i]) begin
                if (found) begin
                    multi_out = 1'b1;
                end else begin
                    grant_out[i] = 1'b1;
                    found        = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/spi_response_arbiter.sv
// Arbitrates per-responder SPI response bytes onto one path, one owner per transaction.
// Optional response timeout enabled by defining SPI_RESPONSE_TIMEOUT_EN.
module spi_response_arbiter
    import spi_response_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 3,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   clock_in,
    input  logic                   reset_in,
    input  logic [7:0]             opcode_in,
    input  logic                   opcode_valid_in,
    input  logic [8*NUM_REQ-1:0]   response_in,
    input  logic [NUM_REQ-1:0]     response_valid_in,
    output logic [7:0]             response_out,
    output logic                   response_valid_out,
    output logic [NUM_REQ-1:0]     grant_out,
    output logic                   collision_out,
    output logic                   timeout_out
);

    state_e               state_q, state_d;
    logic [7:0]           response_q, response_d;
    logic                 valid_q, valid_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic                 collision_q, collision_d;
    logic                 seen_low_q, seen_low_d;
    logic [NUM_REQ-1:0]   pick;
    logic                 multi;
    logic [7:0]           sel_byte;
    logic                 sel_valid;
    logic                 unused_opcode;

    // Opcode is carried on the interface for the peripheral; arbitration ignores it.
    assign unused_opcode = ^opcode_in;

`ifdef SPI_RESPONSE_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_q, timeout_d;
    assign timeout_out = timeout_q;
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
    assign timeout_out = 1'b0;
`endif

    spi_priority_select #(.NUM_REQ(NUM_REQ)) u_select (
        .req_in    (response_valid_in),
        .grant_out (pick),
        .multi_out (multi)
    );

    always_comb begin
        sel_byte  = '0;
        sel_valid = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                sel_byte  = response_in[8*i +: 8];
                sel_valid = response_valid_in[i];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        response_d  = IDLE_RESPONSE_BYTE;
        valid_d     = 1'b0;
        grant_d     = '0;
        collision_d = 1'b0;
        // A transaction may only start after opcode_valid_in has been low for a cycle.
        seen_low_d  = !opcode_valid_in;
`ifdef SPI_RESPONSE_TIMEOUT_EN
        cnt_d       = cnt_q;
        timeout_d   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (opcode_valid_in && seen_low_q) begin
                    state_d = S_WAIT;
`ifdef SPI_RESPONSE_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            S_WAIT: begin
                if (!opcode_valid_in) begin
                    state_d = S_IDLE;
                end else if (|response_valid_in) begin
                    state_d     = S_HOLD;
                    grant_d     = pick;
                    collision_d = multi;
`ifdef SPI_RESPONSE_TIMEOUT_EN
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    state_d    = S_TIMEOUT;
                    timeout_d  = 1'b1;
                    response_d = NO_RESPONSE_BYTE;
                    valid_d    = 1'b1;
                end else begin
                    cnt_d = (cnt_q == CW'(TIMEOUT_CYCLES)) ? cnt_q : cnt_q + 1'b1;
`endif
                end
            end
            S_HOLD: begin
                if (!opcode_valid_in) begin
                    state_d = S_IDLE;
                end else begin
                    grant_d    = grant_q;
                    response_d = sel_byte;
                    valid_d    = sel_valid;
                end
            end
`ifdef SPI_RESPONSE_TIMEOUT_EN
            S_TIMEOUT: begin
                if (!opcode_valid_in) begin
                    state_d = S_IDLE;
                end else begin
                    response_d = NO_RESPONSE_BYTE;
                    valid_d    = 1'b1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state_q     <= S_IDLE;
            response_q  <= IDLE_RESPONSE_BYTE;
            valid_q     <= 1'b0;
            grant_q     <= '0;
            collision_q <= 1'b0;
            seen_low_q  <= 1'b0;
`ifdef SPI_RESPONSE_TIMEOUT_EN
            cnt_q       <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            response_q  <= response_d;
            valid_q     <= valid_d;
            grant_q     <= grant_d;
            collision_q <= collision_d;
            seen_low_q  <= seen_low_d;
`ifdef SPI_RESPONSE_TIMEOUT_EN
            cnt_q       <= cnt_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    assign response_out       = response_q;
    assign response_valid_out = valid_q;
    assign grant_out          = grant_q;
    assign collision_out      = collision_q;

endmodule

// File: tb/tb_spi_response_arbiter.sv
// Randomized plus directed bench for spi_response_arbiter against a transaction-level model.
module tb_spi_response_arbiter;

    localparam int NR = 3;
    localparam int TO = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0]        op;
    logic              opv;
    logic [8*NR-1:0]   resp;
    logic [NR-1:0]     rv;
    logic [7:0]        resp_out;
    logic              resp_vld_out;
    logic [NR-1:0]     grant;
    logic              coll;
    logic              tout;

    int errors = 0;
    int checks = 0;

    // transaction-level model state
    bit         m_active, m_armed, m_tout;
    int         m_owner, m_waited;
    logic [7:0] e_resp;
    logic       e_valid, e_coll, e_to;
    logic [NR-1:0] e_grant;

    spi_response_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TO)) dut (
        .clock_in           (clk),
        .reset_in           (rst),
        .opcode_in          (op),
        .opcode_valid_in    (opv),
        .response_in        (resp),
        .response_valid_in  (rv),
        .response_out       (resp_out),
        .response_valid_out (resp_vld_out),
        .grant_out          (grant),
        .collision_out      (coll),
        .timeout_out        (tout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_update();
        bit armed_now;
        e_resp = 8'h00; e_valid = 1'b0; e_grant = '0; e_coll = 1'b0; e_to = 1'b0;
        if (rst) begin
            m_active = 0; m_owner = -1; m_armed = 0; m_tout = 0; m_waited = 0;
        end else begin
            armed_now = m_armed;
            m_armed   = !opv;
            if (!m_active) begin
                if (opv && armed_now) begin
                    m_active = 1; m_owner = -1; m_waited = 0; m_tout = 0;
                end
            end else if (!opv) begin
                m_active = 0;
            end else if (m_owner >= 0) begin
                e_grant = NR'(1 << m_owner);
                e_resp  = resp[m_owner*8 +: 8];
                e_valid = rv[m_owner];
            end else if (m_tout) begin
                e_resp = 8'hFF; e_valid = 1'b1;
            end else if (rv != '0) begin
                for (int i = NR - 1; i >= 0; i--) if (rv[i]) m_owner = i;
                e_grant = NR'(1 << m_owner);
                e_coll  = ($countones(rv) > 1);
            end else begin
                m_waited++;
`ifdef SPI_RESPONSE_TIMEOUT_EN
                if (m_waited == TO) begin
                    m_tout = 1; e_to = 1'b1; e_resp = 8'hFF; e_valid = 1'b1;
                end
`endif
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check("response_out", 32'(resp_out), 32'(e_resp));
        check("response_valid_out", 32'(resp_vld_out), 32'(e_valid));
        check("grant_out", 32'(grant), 32'(e_grant));
        check("collision_out", 32'(coll), 32'(e_coll));
        check("timeout_out", 32'(tout), 32'(e_to));
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        int run;
        rst = 1'b1; opv = 1'b0; op = 8'h00; rv = '0; resp = '0;
        m_owner = -1;
        steps(2);
        rst = 1'b0;
        steps(2);

        // single responder 1
        opv = 1'b1; op = 8'hDB; steps(2);
        rv = 3'b010; resp[15:8] = 8'h81; steps(3);
        opv = 1'b0; rv = '0; steps(2);

        // responders 0 and 2 together
        opv = 1'b1; op = 8'h9F; steps(1);
        rv = 3'b101; resp[7:0] = 8'h11; resp[23:16] = 8'h22; steps(3);
        opv = 1'b0; rv = '0; steps(2);

        // hold: late responder 2 ignored, granted drop only clears valid
        opv = 1'b1; steps(1);
        rv = 3'b010; resp[15:8] = 8'hAA; steps(2);
        rv = 3'b110; resp[23:16] = 8'h55; steps(2);
        rv = 3'b100; steps(2);

        // reset during hold; no new grant until opv toggles
        rst = 1'b1; steps(1);
        rst = 1'b0; rv = 3'b001; steps(3);
        opv = 1'b0; steps(1);
        opv = 1'b1; steps(3);
        opv = 1'b0; rv = '0; steps(2);

        // no responder: timeout when enabled, silent otherwise
        opv = 1'b1; steps(14);
        opv = 1'b0; steps(2);

        // end of transaction wins over a simultaneous response
        opv = 1'b1; steps(2);
        opv = 1'b0; rv = 3'b001; steps(2);
        rv = '0; steps(1);

        run = 0;
        for (int c = 0; c < 4000; c++) begin
            if (run == 0) begin
                opv = ~opv;
                run = opv ? $urandom_range(1, 25) : $urandom_range(1, 4);
            end
            run--;
            op   = 8'($urandom);
            resp = 24'($urandom);
            rv   = ($urandom_range(0, 9) == 0) ? NR'($urandom) : '0;
            rst  = ($urandom_range(0, 299) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
